watchdog_reset: RTL and testbench

// Watchdog that is the assertion side of our reset scheme: the power-on generator releases reset,

---
 rtl/watchdog_reset_pkg.sv | 15 +
 rtl/watchdog_counter.sv | 22 ++
 rtl/watchdog_reset.sv | 69 ++++++
 tb/tb_watchdog_reset.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/watchdog_reset_pkg.sv
// watchdog_reset_pkg: shared state encoding, default timing constants and helpers
package watchdog_reset_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIRE = 2'd2
  } state_t;
  // Defaults for the 48.828 kHz clock, shared with the power-on reset generator
  localparam logic [12:0] DEF_TIMEOUT = 13'd4883;
  localparam logic [12:0] DEF_WARN    = 13'd488;
  localparam logic [7:0]  DEF_PULSE   = 8'd49;
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/watchdog_counter.sv
// watchdog_counter: loadable down-counter that stops at zero instead of wrapping
module watchdog_counter #(
  parameter int             W       = 13,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic         i_dec,
  input  logic [W-1:0] i_load_value,
  output logic [W-1:0] o_count,
  output logic         o_zero
);
  logic [W-1:0] r_count;
  // Load has priority; decrement is suppressed once the count reaches zero
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_count <= RST_VAL;
    else if (i_load) r_count <= i_load_value;
    else if (i_dec && r_count != '0) r_count <= r_count - W'(1);
  assign o_count = r_count;
  assign o_zero  = (r_count == '0);
endmodule

// File: rtl/watchdog_reset.sv
// watchdog_reset: liveness watchdog that requests a system reset pulse on timeout
module watchdog_reset
  import watchdog_reset_pkg::*;
#(
  parameter int           N       = 13,
  parameter logic [N-1:0] TIMEOUT = DEF_TIMEOUT,
  parameter logic [N-1:0] WARN    = DEF_WARN,
  parameter int           M       = 8,
  parameter logic [M-1:0] PULSE   = DEF_PULSE
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic       i_kick,
  output logic       o_reset_req,
  output logic       o_warning,
  output logic       o_expired,
  output logic [7:0] o_fire_count
);
  state_t       r_state;
  state_t       w_next_state;
  logic         r_reset_req, r_warning, r_expired;
  logic [7:0]   r_fire_count;
  logic [N-1:0] w_count, w_next_count;
  logic [M-1:0] w_pcount;
  logic         w_t_zero, w_p_zero, w_run_go, w_fire, w_t_load, w_t_dec;
  // Enable and kick only matter while running; disable outranks kick, kick outranks expiry
  assign w_run_go = (r_state == ST_RUN) && i_enable && !i_kick;
  assign w_fire   = w_run_go && w_t_zero;
  assign w_t_load = (r_state == ST_IDLE) || (r_state == ST_FIRE && w_p_zero) ||
                    (r_state == ST_RUN && !(i_enable && !i_kick));
  assign w_t_dec  = w_run_go && !w_t_zero;
  watchdog_counter #(.W(N), .RST_VAL(TIMEOUT)) u_timeout (
    .i_clk(i_clk), .i_rst(i_reset), .i_load(w_t_load), .i_dec(w_t_dec),
    .i_load_value(TIMEOUT), .o_count(w_count), .o_zero(w_t_zero)
  );
  watchdog_counter #(.W(M), .RST_VAL('0)) u_pulse (
    .i_clk(i_clk), .i_rst(i_reset), .i_load(w_fire), .i_dec(r_state == ST_FIRE),
    .i_load_value(PULSE - M'(1)), .o_count(w_pcount), .o_zero(w_p_zero)
  );
  // Next state and next timeout count, so the registered outputs line up with them
  always_comb begin
    w_next_state = (r_state == ST_IDLE) ? (i_enable ? ST_RUN : ST_IDLE) :
                   (r_state == ST_RUN)  ? (!i_enable ? ST_IDLE : (w_fire ? ST_FIRE : ST_RUN)) :
                   (r_state == ST_FIRE) ? (w_p_zero ? ST_IDLE : ST_FIRE) : ST_IDLE;
    w_next_count = w_t_load ? TIMEOUT : (w_t_dec ? w_count - N'(1) : w_count);
  end
  // FSM with flop outputs: request pulse, early warning, sticky expiry flag, saturating tally
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_reset_req  <= 1'b0;
      r_warning    <= 1'b0;
      r_expired    <= 1'b0;
      r_fire_count <= 8'd0;
    end else begin
      r_state     <= w_next_state;
      r_reset_req <= (w_next_state == ST_FIRE);
      r_warning   <= (w_next_state == ST_RUN) && (w_next_count < WARN);
      if (w_fire) begin
        r_expired    <= 1'b1;
        r_fire_count <= sat_inc8(r_fire_count);
      end
    end
  assign o_reset_req  = r_reset_req;
  assign o_warning    = r_warning;
  assign o_expired    = r_expired;
  assign o_fire_count = r_fire_count;
endmodule

// File: tb/tb_watchdog_reset.sv
// tb_watchdog_reset: directed self-checking bench for watchdog_reset (TIMEOUT=10, WARN=3, PULSE=3)
module tb_watchdog_reset;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       kick = 1'b0;
  logic       o_reset_req, o_warning, o_expired;
  logic [7:0] o_fire_count;
  int         tests = 0;
  int         fails = 0;
  int         rises;
  logic       prev;

  watchdog_reset #(.N(8), .TIMEOUT(8'd10), .WARN(8'd3), .M(4), .PULSE(4'd3)) dut (
    .i_clk(clk), .i_reset(rst), .i_enable(en), .i_kick(kick),
    .o_reset_req(o_reset_req), .o_warning(o_warning),
    .o_expired(o_expired), .o_fire_count(o_fire_count)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  initial begin
    // 1: reset state, then idle with enable low
    repeat (2) tick();
    chk("rst_req", {7'd0, o_reset_req}, 8'd0);
    chk("rst_warn", {7'd0, o_warning}, 8'd0);
    chk("rst_exp", {7'd0, o_expired}, 8'd0);
    chk("rst_fc", o_fire_count, 8'd0);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("t1_req", {7'd0, o_reset_req}, 8'd0);
      chk("t1_warn", {7'd0, o_warning}, 8'd0);
      chk("t1_fc", o_fire_count, 8'd0);
    end
    // 2: regular kicks every 8 cycles keep the count at or above 3
    en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      kick = (i % 8 == 0);
      tick();
      chk("t2_req", {7'd0, o_reset_req}, 8'd0);
      chk("t2_warn", {7'd0, o_warning}, 8'd0);
    end
    // 3: single kick then starve; fire 11 cycles later for 3 cycles, one IDLE, then RUN again
    chk("t3_exp0", {7'd0, o_expired}, 8'd0);
    kick = 1'b1;
    tick();
    kick = 1'b0;
    for (int j = 1; j <= 24; j++) begin
      tick();
      chk("t3_req", {7'd0, o_reset_req}, (j >= 11 && j <= 13) ? 8'd1 : 8'd0);
      chk("t3_warn", {7'd0, o_warning}, ((j >= 8 && j <= 10) || j >= 23) ? 8'd1 : 8'd0);
      if (j == 11) begin
        chk("t3_exp", {7'd0, o_expired}, 8'd1);
        chk("t3_fc", o_fire_count, 8'd1);
      end
    end
    // 4: kick in the count==0 cycle reloads; disable in the count==0 cycle goes idle
    kick = 1'b1;
    tick();
    kick = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      tick();
      chk("t4a_req", {7'd0, o_reset_req}, 8'd0);
      chk("t4a_warn", {7'd0, o_warning}, (j >= 8) ? 8'd1 : 8'd0);
    end
    kick = 1'b1;
    tick();
    chk("t4_kick0_req", {7'd0, o_reset_req}, 8'd0);
    chk("t4_kick0_warn", {7'd0, o_warning}, 8'd0);
    kick = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      tick();
      chk("t4b_req", {7'd0, o_reset_req}, 8'd0);
      chk("t4b_warn", {7'd0, o_warning}, (j >= 8) ? 8'd1 : 8'd0);
    end
    en = 1'b0;
    tick();
    chk("t4_dis_req", {7'd0, o_reset_req}, 8'd0);
    chk("t4_dis_warn", {7'd0, o_warning}, 8'd0);
    tick();
    chk("t4_dis_fc", o_fire_count, 8'd1);
    // 5: inputs toggled during FIRE do not shorten the pulse
    en = 1'b1;
    tick();
    for (int j = 1; j <= 11; j++) begin
      tick();
      chk("t5a_req", {7'd0, o_reset_req}, (j == 11) ? 8'd1 : 8'd0);
    end
    chk("t5a_fc", o_fire_count, 8'd2);
    kick = 1'b1; en = 1'b0;
    tick();
    chk("t5_f2_req", {7'd0, o_reset_req}, 8'd1);
    kick = 1'b0; en = 1'b1;
    tick();
    chk("t5_f3_req", {7'd0, o_reset_req}, 8'd1);
    kick = 1'b1; en = 1'b0;
    tick();
    chk("t5_end_req", {7'd0, o_reset_req}, 8'd0);
    tick();
    chk("t5_idle_req", {7'd0, o_reset_req}, 8'd0);
    chk("t5_idle_fc", o_fire_count, 8'd2);
    // 5b: asynchronous reset in the second FIRE cycle
    en = 1'b1; kick = 1'b0;
    tick();
    for (int j = 1; j <= 11; j++) tick();
    chk("t5b_f1_req", {7'd0, o_reset_req}, 8'd1);
    chk("t5b_fc", o_fire_count, 8'd3);
    tick();
    chk("t5b_f2_req", {7'd0, o_reset_req}, 8'd1);
    #2 rst = 1'b1;
    #1;
    chk("t5b_async_req", {7'd0, o_reset_req}, 8'd0);
    chk("t5b_async_fc", o_fire_count, 8'd0);
    chk("t5b_async_exp", {7'd0, o_expired}, 8'd0);
    tick();
    rst = 1'b0; en = 1'b0;
    tick();
    chk("t5b_post_req", {7'd0, o_reset_req}, 8'd0);
    // 6: 300 unattended expiries; the tally saturates at FF
    en = 1'b1;
    rises = 0;
    prev = 1'b0;
    for (int c = 0; c < 6000 && rises < 300; c++) begin
      tick();
      if (o_reset_req && !prev) begin
        rises++;
        chk("t6_fc", o_fire_count, (rises > 255) ? 8'hFF : 8'(rises));
      end
      prev = o_reset_req;
    end
    chk("t6_done", (rises >= 300) ? 8'd1 : 8'd0, 8'd1);
    chk("t6_sat", o_fire_count, 8'hFF);
    chk("t6_exp", {7'd0, o_expired}, 8'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
